// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch/sequence stage of the 4-bit processor:
// opcode values, FSM phase encodings and instruction-length decode helpers.
package fetch_sequencer_pkg;

    localparam int unsigned OP_W    = 4;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned PHASE_W = 2;

    localparam logic [OP_W-1:0] OP_NOP   = 4'h0;
    localparam logic [OP_W-1:0] OP_LOAD  = 4'h1;
    localparam logic [OP_W-1:0] OP_STORE = 4'h2;
    localparam logic [OP_W-1:0] OP_JUMP  = 4'h3;
    localparam logic [OP_W-1:0] OP_JUMPC = 4'h4;

    localparam logic [PHASE_W-1:0] PH_FETCH_OP  = 2'b00;
    localparam logic [PHASE_W-1:0] PH_FETCH_ARG = 2'b01;
    localparam logic [PHASE_W-1:0] PH_EXEC      = 2'b10;

    // Opcodes that carry a second (address low) byte.
    function automatic logic is_two_byte(input logic [OP_W-1:0] op);
        return (op == OP_LOAD) || (op == OP_STORE) ||
               (op == OP_JUMP) || (op == OP_JUMPC);
    endfunction

    // Opcodes that access the data RAM during EXEC.
    function automatic logic is_ram_op(input logic [OP_W-1:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/fetch_sequencer_program_counter.sv
// Program counter register: sync active-low reset, enable, increment and load.
// Ports: clock, reset (active-low), enable, inc, load, load_value -> pc.
// Load wins over inc; increment wraps modulo 2^PC_W.
module program_counter #(
    parameter int unsigned    PC_W     = 12,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable,
    input  logic            inc,
    input  logic            load,
    input  logic [PC_W-1:0] load_value,
    output logic [PC_W-1:0] pc
);

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else if (enable) begin
            if (load) begin
                pc <= load_value;
            end else if (inc) begin
                pc <= pc + PC_W'(1);
            end
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch/sequence stage: fetches 1- or 2-byte instructions from a
// combinational ROM, presents the RAM address {oprnd,program_byte} with
// registered chips/enableRW strobes in EXEC, and performs JUMP/JUMPC.
// Ports: clock, reset (sync active-low), enable, rom_data, jump_cond in;
//        pc_out, instr, oprnd, program_byte, chips, enableRW, phase out.
import fetch_sequencer_pkg::*;

module fetch_sequencer #(
    parameter int unsigned     PC_W     = 12,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic [BYTE_W-1:0]  rom_data,
    input  logic               jump_cond,
    output logic [PC_W-1:0]    pc_out,
    output logic [OP_W-1:0]    instr,
    output logic [OP_W-1:0]    oprnd,
    output logic [BYTE_W-1:0]  program_byte,
    output logic               chips,
    output logic               enableRW,
    output logic [PHASE_W-1:0] phase
);

    logic [PHASE_W-1:0] state;
    logic [PHASE_W-1:0] state_next;
    logic [BYTE_W-1:0]  ir;
    logic [BYTE_W-1:0]  ir_next;
    logic [BYTE_W-1:0]  pb_next;
    logic               chips_next;
    logic               rw_next;
    logic               pc_inc;
    logic               pc_load;
    logic [OP_W-1:0]    op;

    assign op = ir[BYTE_W-1:OP_W];

    program_counter #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .inc        (pc_inc),
        .load       (pc_load),
        .load_value (PC_W'({ir[OP_W-1:0], program_byte})),
        .pc         (pc_out)
    );

    // State, instruction and RAM strobe registers; all hold while enable is low.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= PH_FETCH_OP;
            ir           <= '0;
            program_byte <= '0;
            chips        <= 1'b0;
            enableRW     <= 1'b0;
        end else if (enable) begin
            state        <= state_next;
            ir           <= ir_next;
            program_byte <= pb_next;
            chips        <= chips_next;
            enableRW     <= rw_next;
        end
    end

    // Next-state, PC control and strobe decode.
    always_comb begin
        state_next = state;
        ir_next    = ir;
        pb_next    = program_byte;
        chips_next = 1'b0;
        rw_next    = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        case (state)
            PH_FETCH_OP: begin
                ir_next    = rom_data;
                pc_inc     = 1'b1;
                state_next = is_two_byte(rom_data[BYTE_W-1:OP_W]) ? PH_FETCH_ARG : PH_EXEC;
            end
            PH_FETCH_ARG: begin
                // Strobes rise on the edge entering EXEC, address already final.
                pb_next    = rom_data;
                pc_inc     = 1'b1;
                state_next = PH_EXEC;
                chips_next = is_ram_op(op);
                rw_next    = (op == OP_STORE);
            end
            PH_EXEC: begin
                state_next = PH_FETCH_OP;
                pc_load    = (op == OP_JUMP) || ((op == OP_JUMPC) && jump_cond);
            end
            default: begin
                state_next = PH_FETCH_OP;
            end
        endcase
    end

    assign instr = ir[BYTE_W-1:OP_W];
    assign oprnd = ir[OP_W-1:0];
    assign phase = state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: instruction-level reference model
// compared every cycle, plus directed literal checks from hand-worked programs.
module tb_fetch_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        jump_cond = 1'b0;
    logic [7:0]  rom_data;
    logic [11:0] pc_out;
    logic [3:0]  instr;
    logic [3:0]  oprnd;
    logic [7:0]  program_byte;
    logic        chips;
    logic        enableRW;
    logic [1:0]  phase;

    logic [7:0]  rom [0:4095];

    int compared   = 0;
    int mismatched = 0;

    always #5 clock = ~clock;

    assign rom_data = rom[pc_out];

    fetch_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .rom_data     (rom_data),
        .jump_cond    (jump_cond),
        .pc_out       (pc_out),
        .instr        (instr),
        .oprnd        (oprnd),
        .program_byte (program_byte),
        .chips        (chips),
        .enableRW     (enableRW),
        .phase        (phase)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Instruction-level model: an instruction starting at m_start, m_k enabled
    // cycles into it, of m_len bytes; EXEC is the cycle where m_k == m_len.
    int unsigned m_start;
    int unsigned m_k;
    int unsigned m_len;
    logic [7:0]  m_ir;
    logic [7:0]  m_pb;
    bit          m_valid = 1'b0;

    always @(posedge clock) begin
        int unsigned mpc;
        if (!reset) begin
            m_start = 0; m_k = 0; m_len = 1; m_ir = 8'h00; m_pb = 8'h00; m_valid = 1'b1;
        end else if (enable && m_valid) begin
            mpc = (m_start + m_k) % 4096;
            if (m_k == 0) begin
                m_ir  = rom[mpc];
                m_len = (m_ir[7:4] >= 4'h1 && m_ir[7:4] <= 4'h4) ? 2 : 1;
                m_k   = 1;
            end else if (m_k < m_len) begin
                m_pb = rom[mpc];
                m_k  = m_k + 1;
            end else begin
                if (m_ir[7:4] == 4'h3 || (m_ir[7:4] == 4'h4 && jump_cond))
                    m_start = {20'd0, m_ir[3:0], m_pb};
                else
                    m_start = (m_start + m_len) % 4096;
                m_k = 0;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clock) begin
        logic [11:0] e_pc;
        logic [1:0]  e_ph;
        logic        e_exec;
        logic        e_cs;
        logic        e_rw;
        if (m_valid) begin
            e_pc   = 12'((m_start + m_k) % 4096);
            e_exec = (m_k != 0) && (m_k == m_len);
            e_ph   = (m_k == 0) ? 2'b00 : (e_exec ? 2'b10 : 2'b01);
            e_cs   = e_exec && (m_ir[7:4] == 4'h1 || m_ir[7:4] == 4'h2);
            e_rw   = e_exec && (m_ir[7:4] == 4'h2);
            check("model{pc,phase,ir,pb,cs,rw}",
                  {pc_out, phase, instr, oprnd, program_byte, chips, enableRW},
                  {e_pc, e_ph, m_ir, m_pb, e_cs, e_rw});
        end
    end

    task automatic cyc(input logic rst_v, input logic en_v, input logic jc_v);
        reset = rst_v; enable = en_v; jump_cond = jc_v;
        @(posedge clock);
        #1;
    endtask

    task automatic run(input int n, input logic jc_v);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, jc_v);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    endtask

    initial begin
        clear_rom();
        @(posedge clock);
        #1;

        // 1: NOP-class 1-byte op
        rom[0] = 8'h05;
        cyc(1'b0, 1'b1, 1'b0);
        check("t1 reset pc", 32'(pc_out), 32'h000);
        check("t1 reset phase", 32'(phase), 32'h0);
        check("t1 reset cs/rw/ir/pb", {22'd0, chips, enableRW, instr, oprnd}, 32'h00);
        run(1, 1'b0);
        check("t1 exec phase", 32'(phase), 32'h2);
        check("t1 exec pc", 32'(pc_out), 32'h001);
        check("t1 exec chips", 32'(chips), 32'h0);
        run(1, 1'b0);
        check("t1 back phase", 32'(phase), 32'h0);

        // 2: STORE 2A 3C
        clear_rom();
        rom[0] = 8'h2A; rom[1] = 8'h3C;
        cyc(1'b0, 1'b1, 1'b0);
        run(1, 1'b0);
        check("t2 arg phase/chips", {29'd0, phase, chips}, {29'd0, 2'b01, 1'b0});
        run(1, 1'b0);
        check("t2 exec cs/rw", {30'd0, chips, enableRW}, 32'h3);
        check("t2 address", 32'({oprnd, program_byte}), 32'hA3C);
        check("t2 exec pc", 32'(pc_out), 32'h002);
        run(1, 1'b0);
        check("t2 after cs/rw", {30'd0, chips, enableRW}, 32'h0);

        // 3: LOAD 1A 3C then JUMP 37 80
        clear_rom();
        rom[0] = 8'h1A; rom[1] = 8'h3C; rom[2] = 8'h37; rom[3] = 8'h80;
        cyc(1'b0, 1'b1, 1'b0);
        run(2, 1'b0);
        check("t3 load cs/rw", {30'd0, chips, enableRW}, 32'h2);
        run(3, 1'b0);
        check("t3 jump exec pc", 32'(pc_out), 32'h004);
        run(1, 1'b0);
        check("t3 jump target", 32'(pc_out), 32'h780);

        // 4: JUMPC not taken, taken, then 2-byte op at FFF wrapping
        clear_rom();
        rom[0] = 8'h4F; rom[1] = 8'hFF; rom[2] = 8'h4F; rom[3] = 8'hFF;
        rom[12'hFFF] = 8'h1B;
        cyc(1'b0, 1'b1, 1'b0);
        run(3, 1'b0);
        check("t4 jumpc fallthrough", 32'(pc_out), 32'h002);
        run(3, 1'b1);
        check("t4 jumpc taken", 32'(pc_out), 32'hFFF);
        run(1, 1'b0);
        check("t4 wrap fetch_op pc", 32'(pc_out), 32'h000);
        run(1, 1'b0);
        check("t4 wrap arg byte", 32'(program_byte), 32'h4F);
        check("t4 wrap pc", 32'(pc_out), 32'h001);
        check("t4 wrap addr", 32'({oprnd, program_byte}), 32'hB4F);

        // 5: stall in STORE EXEC, then reset mid-FETCH_ARG
        clear_rom();
        rom[0] = 8'h2A; rom[1] = 8'h3C; rom[2] = 8'h2B; rom[3] = 8'h11;
        cyc(1'b0, 1'b1, 1'b0);
        run(2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b1);
            check("t5 stall outputs", {pc_out, phase, instr, oprnd, program_byte, chips, enableRW},
                  {12'h002, 2'b10, 4'h2, 4'hA, 8'h3C, 1'b1, 1'b1});
        end
        run(2, 1'b0);
        check("t5 in fetch_arg", {20'd0, pc_out}, 32'h003);
        cyc(1'b0, 1'b1, 1'b0);
        check("t5 reset values", {pc_out, phase, instr, oprnd, program_byte, chips, enableRW}, 32'h0);

        // 6: reset during STORE EXEC
        cyc(1'b0, 1'b1, 1'b0);
        run(2, 1'b0);
        check("t6 exec chips", 32'(chips), 32'h1);
        cyc(1'b0, 1'b1, 1'b0);
        check("t6 reset cs/rw/phase", {28'd0, chips, enableRW, phase}, 32'h0);
        check("t6 reset pc", 32'(pc_out), 32'h000);

        // 7: self-loop JUMP 30 00
        clear_rom();
        rom[0] = 8'h30; rom[1] = 8'h00;
        cyc(1'b0, 1'b1, 1'b0);
        run(3, 1'b0);
        check("t7 self loop 1", 32'(pc_out), 32'h000);
        run(3, 1'b0);
        check("t7 self loop 2", {20'd0, pc_out} | {30'd0, phase}, 32'h000);

        cyc(1'b1, 1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
